// File: rtl/fma_pkg.sv
// Shared types and constants for the accumulator-to-binary32 packer.
package fma_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {IDLE, NORM, RND, OUT} packst;

    localparam logic [31:0] FP_INF  = 32'h7F80_0000;
    localparam int          FP_BIAS = 127;

endpackage

// File: rtl/fma_pack_if.sv
// Output stream of the packer: one binary32 word per lane with its index.
interface fma_pack_if #(parameter int LW = 2);
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [LW-1:0] out_lane;

    modport master (output out_valid, out_data, out_lane, input out_ready);
    modport slave  (input out_valid, out_data, out_lane, output out_ready);
endinterface

// File: rtl/fma_lzc.sv
// 32-bit leading-zero counter; returns 32 for an all-zero input.
module fma_lzc (
    input  logic [31:0] x,
    output logic [5:0]  cnt
);
    // Scanning upward lets the highest set bit win.
    always_comb begin
        cnt = 6'd32;
        for (int i = 0; i < 32; i++)
            if (x[i]) cnt = 6'(31 - i);
    end
endmodule

// File: rtl/fma_pack.sv
// Snapshots the four accumulator lanes and serializes them as rounded,
// flushed and saturated binary32 words on a valid/ready stream.
module fma_pack
    import fma_pkg::*;
#(
    parameter int FRAC_POS = 30,
    parameter int LANES    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] acc0, acc1, acc2, acc3,
    input  logic [9:0]  exp0, exp1, exp2, exp3,
    output logic        busy,
    output logic        done,
    fma_pack_if.master  out
);
    localparam int LW      = $clog2(LANES);
    localparam int EXP_MAX = 2 * FP_BIAS + 1;

    packst state_q, state_d;

    logic [LANES-1:0][31:0] acc_q;
    logic [LANES-1:0][9:0]  exp_q;
    logic [LW-1:0]          lane_q;
    logic                   busy_q, done_q;

    logic                   sign_q, zero_q;
    logic [31:0]            m_q;
    logic [4:0]             p_q;
    logic signed [11:0]     e_q;

    logic                   valid_q;
    logic [31:0]            data_q;
    logic [LW-1:0]          olane_q;

    logic fire, last, take_start;

    // Normalize stage
    logic [31:0]        cur_acc, m_n;
    logic [5:0]         lz;
    logic [4:0]         p_n;
    logic signed [11:0] e_n;

    assign cur_acc = acc_q[lane_q];
    assign m_n     = cur_acc[31] ? (~cur_acc + 32'd1) : cur_acc;
    assign p_n     = 5'd31 - lz[4:0];
    assign e_n     = 12'({2'b00, exp_q[lane_q]}) - 12'(FRAC_POS) + 12'({7'b0, p_n});

    fma_lzc u_lzc (.x(m_n), .cnt(lz));

    // Round stage: shift the leading one to bit 31 so frac/guard/sticky sit
    // at fixed positions; small p shifts left exactly and leaves guard/sticky 0.
    logic [31:0]        mn;
    logic               rnd_up;
    logic [23:0]        frac_inc;
    logic signed [11:0] e_r;
    fp32_t              res;

    always_comb begin
        mn       = m_q << (5'd31 - p_q);
        rnd_up   = mn[7] & ((|mn[6:0]) | mn[8]);
        frac_inc = {1'b0, mn[30:8]} + 24'(rnd_up);
        e_r      = e_q + 12'(frac_inc[23]);
        if (zero_q | ~mn[31])
            res = '0;
        else if (e_r >= $signed(12'(EXP_MAX)))
            res = FP_INF | {sign_q, 31'b0};
        else if (e_r <= 12'sd0)
            res = {sign_q, 31'b0};
        else
            res = '{sign: sign_q, exp: e_r[7:0], frac: frac_inc[22:0]};
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = NORM;
            NORM: state_d = RND;
            RND:  state_d = OUT;
            OUT:  if (fire) state_d = last ? IDLE : NORM;
            default: state_d = IDLE;
        endcase
    end

    // FSM: control outputs
    always_comb begin
        take_start = (state_q == IDLE) & start;
        fire       = (state_q == OUT) & valid_q & out.out_ready;
        last       = (lane_q == LW'(LANES - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q   <= '0;
            exp_q   <= '0;
            lane_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
            m_q     <= '0;
            p_q     <= '0;
            e_q     <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            olane_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (take_start) begin
                acc_q  <= {acc3, acc2, acc1, acc0};
                exp_q  <= {exp3, exp2, exp1, exp0};
                lane_q <= '0;
                busy_q <= 1'b1;
            end
            if (state_q == NORM) begin
                sign_q <= cur_acc[31];
                zero_q <= lz[5];
                m_q    <= m_n;
                p_q    <= p_n;
                e_q    <= e_n;
            end
            if (state_q == RND) begin
                data_q  <= res;
                olane_q <= lane_q;
                valid_q <= 1'b1;
            end
            if (fire) begin
                valid_q <= 1'b0;
                if (last) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    lane_q <= lane_q + LW'(1);
                end
            end
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign out.out_valid = valid_q;
    assign out.out_data  = data_q;
    assign out.out_lane  = olane_q;

endmodule

// File: doc/fma_pack.md
Name: fma_pack

Overview:
- Reads the four accumulator lanes of the fmab datapath, acc0..3 with their block exponents exp0..3, and converts each lane to IEEE-754 binary32.
- Conversion per lane: normalize, round to nearest even, flush-to-zero, saturate to infinity.
- Emits one lane at a time on a valid/ready stream. It is the consumer/output end of the fmab accumulator interface.
- A start pulse snapshots all four lanes, so fmab may begin its next accumulation immediately.

Parameters:
- FRAC_POS, 30: bit position in accN whose weight is 2^(expN-127), i.e. the binary point; 1.0 = acc 0x40000000 with exp 127.
- LANES, 4: number of accumulator lanes serialized per start.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low; low clears all state immediately.
- start  in  1  pulse; snapshot acc0..3/exp0..3 when idle.
- acc0, acc1, acc2, acc3  in  32 each  signed two's-complement lane mantissas.
- exp0, exp1, exp2, exp3  in  10 each  unsigned lane exponents.
- busy  out  1  high from accepted start until the last lane handshake.
- out_valid  out  1  out_data/out_lane valid.
- out_ready  in  1  downstream accept.
- out_data  out  32  binary32 result.
- out_lane  out  2  lane index of out_data.
- done  out  1  one-cycle pulse in the cycle after the last lane is accepted.

Behaviour:
- Reset (reset=0, async): state=IDLE; busy, out_valid and done = 0; out_data and out_lane = 0; snapshot registers cleared. Reset mid-operation abandons the remaining lanes with no done pulse.
- FSM states are IDLE, NORM, RND and OUT.
- IDLE: start=1 captures all lanes, sets lane=0 and busy=1, and moves to NORM. start is ignored in every other state, with no queuing.
- NORM (1 cycle):
  - sign = acc[31]; m = |acc| as a 32-bit unsigned value (0x80000000 gives m=2^31).
  - Leading-one position p = 31 - lzc(m).
  - Signed 12-bit E = exp - FRAC_POS + p + 0 (biased binary32 exponent). Register sign, m, p, E and the zero flag.
- RND (1 cycle):
  - If p > 23: frac = m[p-1:p-23]; guard = m[p-24]; sticky = OR of the bits below guard. Round up if guard & (sticky | frac[0]).
  - A round-up carry out of frac sets frac = 0 and E = E+1.
  - If p <= 23: left-shift exactly, with no rounding.
  - Then apply, in priority order: m==0 gives +0 (0x00000000); E >= 255 gives sign|0x7F800000; E <= 0 gives sign|0 (FTZ, no subnormals); otherwise {sign, E[7:0], frac}.
  - Register into out_data, set out_lane = lane and out_valid = 1, and move to OUT.
- OUT: hold out_data, out_lane and out_valid stable while out_ready=0. On out_valid & out_ready:
  - if lane = LANES-1: go to IDLE, drop busy and out_valid, pulse done next cycle;
  - otherwise lane++, drop out_valid, go to NORM.
- Latency: start at cycle 0 gives out_valid at cycle 3. Each lane takes 3 cycles with out_ready held high, so 12 cycles for four lanes.
- start coinciding with the final handshake is ignored (busy still 1). out_valid never asserts outside OUT.

Decomposition:
- Shared package fma_pkg holds:
  - typedef struct packed fp32_t {sign, exp[7:0], frac[22:0]};
  - enum packst {IDLE, NORM, RND, OUT};
  - constants FP_INF = 0x7F800000 and FP_BIAS = 127.
- Sub-module fma_lzc: combinational 32-bit leading-zero counter, 6-bit result, 32 when the input is zero. Instantiated once in NORM.

Test Plan:
- All lanes = {acc 0x40000000, exp 127}, out_ready=1 -> out_data 0x3F800000 on lanes 0,1,2,3 at cycles 3, 6, 9, 12; done at 13.
- acc0 = 0xC0000000 / exp 127 -> 0xBF800000; acc1 = 0 / exp 500 -> 0x00000000; acc2 = 0x80000000 / exp 127 -> 0xC0000000; acc3 = 0x00000001 / exp 157 -> 0x3F800000.
- Rounding with exp 127: acc 0x7FFFFFFF -> 0x40000000 (carry into exponent); 0x40000040 -> 0x3F800000 (tie, even); 0x400000C0 -> 0x3F800002 (tie, odd up); 0x40000041 -> 0x3F800001.
- Range with acc 0x40000000: exp 300 -> 0x7F800000; exp 0 -> 0x00000000 (FTZ); acc 0xC0000000 / exp 400 -> 0xFF800000.
- Backpressure: hold out_ready=0 for 5 cycles on lane 1 -> out_data/out_lane stable and lane 2 not started. Also assert a second start while busy -> ignored, exactly 4 outputs, 1 done.
- Assert reset=0 asynchronously during lane 2 OUT -> out_valid, busy and out_data drop immediately with no done pulse. After release, a new start produces lanes 0..3 from the new snapshot.
